spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Owns the single-port RAM behind the SPI slave and shares it between two requesters.
- Requester A is the SPI command stream (10-bit rx words), which cannot be stalled.
- Requester B is an on-chip host req/gnt port.
- Decodes SPI commands, buffers one SPI RAM access, arbitrates round-robin, drives the RAM port (registered) and routes read data back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 8, RAM address width; SPI rx word is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 8, RAM data width; must equal ADDR_WIDTH (SPI payload field is shared).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- spi_rx_data  in  ADDR_WIDTH+2  [9:8]=cmd, [7:0]=payload
- spi_rx_valid  in  1  one-cycle strobe, rx word valid
- spi_tx_data  out  DATA_WIDTH  read data to SPI slave
- spi_tx_valid  out  1  one-cycle strobe, spi_tx_data valid
- spi_overflow  out  1  sticky: SPI access dropped
- b_req  in  1  host request; held until b_gnt
- b_we  in  1  1=write, 0=read
- b_addr  in  ADDR_WIDTH  host address
- b_wdata  in  DATA_WIDTH  host write data
- b_gnt  out  1  combinational acceptance, same cycle as winning b_req
- b_rvalid  out  1  one-cycle strobe, b_rdata valid
- b_rdata  out  DATA_WIDTH  host read data
- ram_en  out  1  RAM access enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_wdata  out  DATA_WIDTH  RAM write data (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en=1, ram_we=0

Behaviour:
- Reset: every output is 0; wr_addr_q=0, rd_addr_q=0, a_pend=0, last_grant=B (A wins the first tie), read-tag pipeline cleared. In-flight reads are discarded and produce no strobe.
- SPI decode on spi_rx_valid:
  - 00: wr_addr_q<=payload. No RAM access.
  - 10: rd_addr_q<=payload. No RAM access.
  - 01: pending write {wr_addr_q, payload}.
  - 11: pending read at rd_addr_q; payload ignored.
- Pending entry captures its address at arrival. Later 00/10 commands do not alter an already-pending entry.
- a_pend visibility: set in the cycle after the 01/11 strobe; cleared in the cycle A is granted.
- Simultaneous A grant and new 01/11 arrival: the old entry issues and the new one becomes pending; no overflow.
- New 01/11 while a_pend=1 and A is not granted that cycle: the new command is dropped, the pending entry is kept, and spi_overflow<=1. spi_overflow clears only on rst.
- Arbitration, evaluated every cycle:
  - Candidates are a_pend and b_req. A single candidate wins.
  - On a tie, the winner is the requester not equal to last_grant. last_grant updates on every grant.
  - At most one grant per cycle; back-to-back grants are allowed.
- Timing, with G = grant cycle:
  - ram_* presented in G+1.
  - ram_rdata valid in G+2.
  - spi_tx_valid or b_rvalid pulses in G+3, with data captured from ram_rdata.
  - Writes produce no response.
- A 2-stage tag pipeline ({valid, owner}) tracks read ownership; responses are always in issue order.
- With no grant, ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their last value.
- An illegal state is impossible: cmd is fully decoded over 2 bits.

Decomposition:
- Package spi_ram_pkg holds:
  - CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Requester id constants REQ_A=1'b0, REQ_B=1'b1.
- Sub-module rr_arb2: 2-requester round-robin with last_grant register, same reset.
- Top level holds decode, the pending buffer, RAM output registers and the response pipeline.

Test Plan:
- After rst: SPI 0x00A, then 0x15C, no b_req -> ram_en=ram_we=1, ram_addr=0x0A, ram_wdata=0x5C, 2 cycles after the 0x15C strobe.
- SPI 0x20A, then 0x300, RAM returns 0x5C -> spi_tx_data=0x5C with a one-cycle spi_tx_valid, 4 cycles after the 0x300 strobe; b_rvalid stays 0.
- Tie after reset: a_pend=1 (write 0x33 to 0x01) and b_req read 0x02 in the same cycle -> A granted first, B granted next cycle. A second tie goes to A only if B won last.
- Host write then read: b_we=1, addr 0x10, data 0xA5, then read 0x10 -> b_gnt pulses, b_rdata=0xA5 with b_rvalid at G+3.
- Overflow: set last_grant=A, hold b_req=1, SPI 0x111 at t and 0x122 at t+1 -> spi_overflow=1 from t+2; only data 0x11 is written and 0x22 never appears on ram_wdata.
- Reset mid-read: assert rst in G+1 of an SPI read -> no spi_tx_valid, all outputs 0 in the cycle after rst, and a_pend is cleared.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI/host RAM arbiter.
// SPI command encodings, requester ids and the read-ownership tag.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not
// win last time is granted. last_grant resets to B so A wins the first tie.
module rr_arb2
    import spi_ram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_grant_q;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (last_grant_q == REQ_A) gnt_b = 1'b1;
            else                       gnt_a = 1'b1;
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        last_grant_q <= REQ_B;
        else if (gnt_a) last_grant_q <= REQ_A;
        else if (gnt_b) last_grant_q <= REQ_B;
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the unstallable SPI command stream (A)
// and a host req/gnt port (B); read data is routed back in issue order.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH+1:0] spi_rx_data,
    input  logic                  spi_rx_valid,
    output logic [DATA_WIDTH-1:0] spi_tx_data,
    output logic                  spi_tx_valid,
    output logic                  spi_overflow,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;

    logic                  a_pend_q, a_we_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic [DATA_WIDTH-1:0] a_wdata_q;

    logic    a_new, a_load;
    logic    req_a, req_b, gnt_a, gnt_b;
    rd_tag_t tag1_q, tag2_q;

    assign cmd     = spi_rx_data[ADDR_WIDTH+1:ADDR_WIDTH];
    assign payload = spi_rx_data[ADDR_WIDTH-1:0];

    // A new entry may replace the pending one only if that one issues this cycle.
    always_comb begin
        a_new  = spi_rx_valid && ((cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA));
        a_load = a_new && (!a_pend_q || gnt_a);
    end

    // Grants are suppressed during reset so no host request is silently accepted.
    assign req_a = a_pend_q && !rst;
    assign req_b = b_req && !rst;
    assign b_gnt = gnt_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            a_pend_q     <= 1'b0;
            a_we_q       <= 1'b0;
            a_addr_q     <= '0;
            a_wdata_q    <= '0;
            spi_overflow <= 1'b0;
        end else begin
            if (spi_rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr_q <= payload;
                    CMD_RD_ADDR: rd_addr_q <= payload;
                    default: ;
                endcase
            end
            if (a_load) begin
                a_pend_q  <= 1'b1;
                a_we_q    <= (cmd == CMD_WR_DATA);
                a_addr_q  <= (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
                a_wdata_q <= DATA_WIDTH'(payload);
            end else if (a_new) begin
                spi_overflow <= 1'b1;
            end else if (gnt_a) begin
                a_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (gnt_a) begin
            ram_en    <= 1'b1;
            ram_we    <= a_we_q;
            ram_addr  <= a_addr_q;
            ram_wdata <= a_wdata_q;
        end else if (gnt_b) begin
            ram_en    <= 1'b1;
            ram_we    <= b_we;
            ram_addr  <= b_addr;
            ram_wdata <= b_wdata;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
        end
    end

    // tag1 lines up with the RAM port, tag2 with ram_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_q       <= '0;
            tag2_q       <= '0;
            spi_tx_valid <= 1'b0;
            spi_tx_data  <= '0;
            b_rvalid     <= 1'b0;
            b_rdata      <= '0;
        end else begin
            tag1_q.valid <= (gnt_a && !a_we_q) || (gnt_b && !b_we);
            tag1_q.owner <= gnt_b ? REQ_B : REQ_A;
            tag2_q       <= tag1_q;
            spi_tx_valid <= tag2_q.valid && (tag2_q.owner == REQ_A);
            b_rvalid     <= tag2_q.valid && (tag2_q.owner == REQ_B);
            if (tag2_q.valid && (tag2_q.owner == REQ_A)) spi_tx_data <= ram_rdata;
            if (tag2_q.valid && (tag2_q.owner == REQ_B)) b_rdata     <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed checks of the arbiter's timing and corner cases, then a randomized
// run scored against a memory/queue model of what each requester should see.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid, spi_overflow;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_overflow (spi_overflow),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Bench RAM: synchronous read, unwritten locations return a fixed pattern.
    logic [7:0] ram_mem [256];
    bit         written [256];

    function automatic logic [7:0] ram_default(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? ram_mem[ram_addr] : ram_default(ram_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic spi(input logic [9:0] w);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        spi_rx_valid = 1'b0;
        b_req        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({spi_tx_data, spi_tx_valid, spi_overflow, b_gnt, b_rvalid, b_rdata,
                    ram_en, ram_we, ram_addr, ram_wdata});
    endfunction

    typedef struct {
        bit         chk;
        logic [7:0] d;
    } exp_t;

    exp_t       spi_q[$];
    exp_t       b_q[$];
    exp_t       e;
    logic [7:0] exp_mem [256];
    bit         known [256];
    logic [7:0] m_wr, m_rd, pl;
    logic [1:0] c;
    int         cool, wait_b;
    bit         b_done, active;

    initial begin
        spi_rx_data = '0;
        b_we        = 1'b0;
        b_addr      = '0;
        b_wdata     = '0;
        do_reset();
        smp();
        check("reset_outputs", all_outs(), 64'd0);

        // Write 0x5C to 0x0A: RAM port active two cycles after the data strobe.
        tick();
        spi(10'h00A);
        spi(10'h15C);
        smp();
        check("t1_no_early_en", ram_en, 1'b0);
        tick();
        smp();
        check("t1_ram_en", ram_en, 1'b1);
        check("t1_ram_we", ram_we, 1'b1);
        check("t1_ram_addr", ram_addr, 8'h0A);
        check("t1_ram_wdata", ram_wdata, 8'h5C);
        tick();
        smp();
        check("t1_en_one_cycle", ram_en, 1'b0);

        // SPI read of 0x0A: one tx strobe four cycles after the strobe.
        tick();
        spi(10'h20A);
        spi(10'h300);
        for (int k = 1; k <= 5; k++) begin
            smp();
            check("t2_tx_valid", spi_tx_valid, k == 4);
            check("t2_b_rvalid_quiet", b_rvalid, 1'b0);
            if (k == 4) check("t2_tx_data", spi_tx_data, 8'h5C);
            tick();
        end

        // Tie after reset: A first, B the next cycle.
        do_reset();
        spi(10'h001);
        spi_rx_data  = 10'h133;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = 8'h02;
        smp();
        check("t3_tie_a_first", b_gnt, 1'b0);
        tick();
        smp();
        check("t3_b_next", b_gnt, 1'b1);
        check("t3_a_port", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h01, 8'h33});
        tick();
        b_req = 1'b0;
        smp();
        check("t3_b_port", {ram_en, ram_we, ram_addr}, {2'b10, 8'h02});
        tick();
        smp();
        check("t3_b_rvalid_early", b_rvalid, 1'b0);
        tick();
        smp();
        check("t3_b_rvalid", b_rvalid, 1'b1);
        check("t3_b_rdata", b_rdata, ram_default(8'h02));

        // last grant was B, so the next tie still goes to A
        tick();
        spi_rx_data  = 10'h144;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        b_req  = 1'b1;
        b_addr = 8'h03;
        smp();
        check("t3_tie2_a", b_gnt, 1'b0);
        tick();
        smp();
        check("t3_tie2_b_next", b_gnt, 1'b1);
        tick();
        b_req = 1'b0;
        tick();
        tick();
        // lone A grant, then a tie with last grant A goes to B
        spi_rx_data  = 10'h155;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_data = 10'h166;
        tick();
        spi_rx_valid = 1'b0;
        b_req  = 1'b1;
        b_addr = 8'h04;
        smp();
        check("t3_tie_b_wins", b_gnt, 1'b1);
        check("t3_a55_port", {ram_en, ram_we, ram_wdata}, {2'b11, 8'h55});
        tick();
        b_req = 1'b0;
        smp();
        check("t3_b_after_tie", {ram_en, ram_we, ram_addr}, {2'b10, 8'h04});
        tick();
        smp();
        check("t3_a66_port", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h01, 8'h66});
        check("t3_no_overflow", spi_overflow, 1'b0);

        // Host write then read back of 0x10.
        tick();
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 8'h10;
        b_wdata = 8'hA5;
        smp();
        check("t4_wr_gnt", b_gnt, 1'b1);
        tick();
        b_we = 1'b0;
        smp();
        check("t4_rd_gnt", b_gnt, 1'b1);
        tick();
        b_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            smp();
            check("t4_rvalid", b_rvalid, k == 3);
            if (k == 3) check("t4_rdata", b_rdata, 8'hA5);
            tick();
        end

        // Overflow: second write arrives while B wins the tie and is dropped.
        do_reset();
        spi(10'h020);
        spi(10'h1EE);
        tick();
        tick();
        spi_rx_data  = 10'h111;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_data = 10'h122;
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = 8'h40;
        smp();
        check("t5_b_wins_tie", b_gnt, 1'b1);
        check("t5_ovf_not_yet", spi_overflow, 1'b0);
        tick();
        spi_rx_valid = 1'b0;
        b_addr = 8'h41;
        smp();
        check("t5_overflow_set", spi_overflow, 1'b1);
        check("t5_a_wins", b_gnt, 1'b0);
        check("t5_b_read_port", {ram_en, ram_we}, 2'b10);
        tick();
        smp();
        check("t5_b_again", b_gnt, 1'b1);
        check("t5_write_11", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h20, 8'h11});
        tick();
        b_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp();
            check("t5_no_second_write", ram_en && ram_we, 1'b0);
            tick();
        end
        smp();
        check("t5_overflow_sticky", spi_overflow, 1'b1);

        // Reset in the cycle after an SPI read grant.
        do_reset();
        spi(10'h2AA);
        spi_rx_data  = 10'h300;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_data = 10'h311;
        tick();
        spi_rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check("t6_outputs_zero", all_outs(), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            smp();
            check("t6_no_tx", spi_tx_valid, 1'b0);
            check("t6_no_access", ram_en, 1'b0);
        end

        // Randomized run: A uses 0x00-0x0F, B uses 0x80-0x8F, so each side's
        // reads see only its own earlier writes whatever the interleaving.
        do_reset();
        m_wr   = '0;
        m_rd   = '0;
        cool   = 0;
        wait_b = 0;
        b_done = 1'b0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        for (int i = 0; i < 640; i++) begin
            active = (i < 600);
            if (i > 0) tick();
            spi_rx_valid = 1'b0;
            if (b_done) begin
                b_req  = 1'b0;
                b_done = 1'b0;
            end
            if (cool > 0) cool--;
            if (active && $urandom_range(0, 1) == 1) begin
                c = 2'($urandom_range(0, 3));
                if (c[0] && cool != 0) c[0] = 1'b0;
                pl = c[0] ? 8'($urandom) : {4'h0, 4'($urandom)};
                case (c)
                    2'b00: m_wr = pl;
                    2'b10: m_rd = pl;
                    2'b01: begin
                        exp_mem[m_wr] = pl;
                        known[m_wr]   = 1'b1;
                    end
                    default: begin
                        e.chk = known[m_rd];
                        e.d   = exp_mem[m_rd];
                        spi_q.push_back(e);
                    end
                endcase
                if (c[0]) cool = 3;
                spi_rx_data  = {c, pl};
                spi_rx_valid = 1'b1;
            end
            if (active && !b_req && $urandom_range(0, 1) == 1) begin
                b_req   = 1'b1;
                b_we    = 1'($urandom);
                b_addr  = {4'h8, 4'($urandom)};
                b_wdata = 8'($urandom);
                wait_b  = 0;
            end
            smp();
            check("rnd_gnt_without_req", b_gnt && !b_req, 1'b0);
            if (b_req && b_gnt) begin
                check("rnd_b_latency", wait_b <= 1, 1'b1);
                if (b_we) begin
                    exp_mem[b_addr] = b_wdata;
                    known[b_addr]   = 1'b1;
                end else begin
                    e.chk = known[b_addr];
                    e.d   = exp_mem[b_addr];
                    b_q.push_back(e);
                end
                b_done = 1'b1;
            end else if (b_req) begin
                wait_b++;
            end
            if (spi_tx_valid) begin
                check("rnd_spi_resp_expected", spi_q.size() != 0, 1'b1);
                if (spi_q.size() != 0) begin
                    e = spi_q.pop_front();
                    if (e.chk) check("rnd_spi_rdata", spi_tx_data, e.d);
                end
            end
            if (b_rvalid) begin
                check("rnd_b_resp_expected", b_q.size() != 0, 1'b1);
                if (b_q.size() != 0) begin
                    e = b_q.pop_front();
                    if (e.chk) check("rnd_b_rdata", b_rdata, e.d);
                end
            end
        end
        check("rnd_spi_all_answered", spi_q.size(), 0);
        check("rnd_b_all_answered", b_q.size(), 0);
        check("rnd_b_not_stuck", b_req && !b_done, 1'b0);
        check("rnd_no_overflow", spi_overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
